// File: rtl/instr_decoder_pkg.sv
// Shared types and constants for the nibble-immediate instruction decoder:
// opcode classes, special opcodes, source-mux codes and register-enable bit positions.
package instr_decoder_pkg;

    localparam logic [7:0] EXT_OP_DFLT = 8'hC8;
    localparam logic [7:0] NOP_CF      = 8'hCF;
    localparam logic [7:0] NOP_D8      = 8'hD8;
    localparam logic [7:0] NOP_DF      = 8'hDF;

    localparam logic [3:0] SRC_IMM  = 4'd8;
    localparam logic [3:0] SRC_SELF = 4'd9;
    localparam logic [3:0] SRC_RST  = 4'd10;
    localparam logic [2:0] SSS_ACC  = 3'd4;

    typedef enum int {
        REG_X0 = 0, REG_X1 = 1, REG_Y0 = 2, REG_Y1 = 3, REG_R = 4,
        REG_M  = 5, REG_I  = 6, REG_DM = 7, REG_OREG = 8
    } reg_bit_e;

    typedef enum logic [1:0] {
        CLS_LOAD = 2'd0,
        CLS_MOVE = 2'd1,
        CLS_ALU  = 2'd2,
        CLS_JUMP = 2'd3
    } op_class_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GOT_PREFIX = 2'd1,
        GOT_DATA   = 2'd2
    } ext_state_e;

    typedef struct packed {
        logic [8:0] reg_en;
        logic [3:0] source_sel;
        logic       i_sel;
        logic       x_sel;
        logic       y_sel;
        logic       jmp;
        logic       jmp_nz;
    } dec_t;

    function automatic op_class_e op_class(input logic [7:0] b);
        if (!b[7]) return CLS_LOAD;
        if (!b[6]) return CLS_MOVE;
        if (!b[5]) return CLS_ALU;
        return CLS_JUMP;
    endfunction

    // Destinations 6 (i) and 7 (dm) both also write the i register.
    function automatic logic [8:0] dest_en(input logic [2:0] d);
        logic [8:0] en;
        en    = '0;
        en[d] = 1'b1;
        if (d[2:1] == 2'b11) en[REG_I] = 1'b1;
        return en;
    endfunction

endpackage

// File: rtl/idec_reg_en_decode.sv
// Purely combinational decode of the instruction register into register enables,
// source select and operand selects; gating by handshake/FSM is done by the top.
module idec_reg_en_decode
    import instr_decoder_pkg::*;
(
    input  logic [7:0] ir,
    output dec_t       dec,
    output logic       uses_imm
);

    logic [2:0] ddd;
    logic [2:0] sss;

    assign ddd = ir[5:3];
    assign sss = ir[2:0];

    always_comb begin
        dec      = '0;
        dec.i_sel = 1'b1;
        uses_imm = 1'b0;
        case (op_class(ir))
            CLS_LOAD: begin
                dec.reg_en     = dest_en(ir[6:4]);
                dec.source_sel = SRC_IMM;
                dec.i_sel      = (ir[6:4] != 3'd6);
                uses_imm       = 1'b1;
            end
            CLS_MOVE: begin
                dec.reg_en = dest_en(ddd);
                if (sss == 3'd7) dec.reg_en[REG_I] = 1'b1;
                // The accumulator source wins over the self-move encoding.
                if (sss == SSS_ACC)
                    dec.source_sel = {1'b0, SSS_ACC};
                else if (sss == ddd)
                    dec.source_sel = SRC_SELF;
                else
                    dec.source_sel = {1'b0, sss};
                dec.i_sel = (ddd != 3'd6);
            end
            CLS_ALU: begin
                dec.reg_en[REG_R] = 1'b1;
                dec.x_sel         = ir[4];
                dec.y_sel         = ir[3];
                dec.source_sel    = {1'b0, sss};
            end
            default: begin
                dec.jmp    = ~ir[4];
                dec.jmp_nz = ir[4];
                uses_imm   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_decoder_ext.sv
// Instruction decoder with valid/stall handshake, extended-immediate prefix FSM and a
// saturating NOP counter. Holds ir and gates the decode produced by idec_reg_en_decode.
module instr_decoder_ext
    import instr_decoder_pkg::*;
#(
    parameter int         DATA_W   = 4,
    parameter logic [7:0] EXT_OP   = EXT_OP_DFLT,
    parameter int         NOPCNT_W = 8
) (
    input  logic                clk,
    input  logic                sync_reset,
    input  logic [7:0]          next_instr,
    input  logic                instr_valid,
    input  logic                stall,
    output logic [7:0]          ir,
    output logic                dec_valid,
    output logic [DATA_W-1:0]   ir_nibble,
    output logic                imm_ext,
    output logic [8:0]          reg_en,
    output logic [7:0]          from_ID,
    output logic [3:0]          source_sel,
    output logic                i_sel,
    output logic                x_sel,
    output logic                y_sel,
    output logic                jmp,
    output logic                jmp_nz,
    output logic [1:0]          ext_state,
    output logic [NOPCNT_W-1:0] nop_count
);

    ext_state_e        state_q, state_d;
    logic [DATA_W-1:0] ext_byte;
    dec_t              raw;
    logic              uses_imm;
    logic              fire;
    logic              is_nop;
    logic              use_ext;
    logic              count_nop;

    assign fire      = dec_valid & ~stall & ~sync_reset;
    assign is_nop    = (ir == NOP_CF) || (ir == NOP_D8) || (ir == NOP_DF) || (ir == EXT_OP);
    assign use_ext   = dec_valid & (state_q == GOT_DATA) & uses_imm;
    // The data byte after a prefix is never counted even if it happens to look like a NOP.
    assign count_nop = fire & is_nop & (state_q != GOT_PREFIX);

    idec_reg_en_decode u_dec (
        .ir       (ir),
        .dec      (raw),
        .uses_imm (uses_imm)
    );

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            ir        <= '0;
            dec_valid <= 1'b0;
        end else if (!stall) begin
            dec_valid <= instr_valid;
            if (instr_valid) ir <= next_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (fire) begin
            case (state_q)
                IDLE:       if (ir == EXT_OP) state_d = GOT_PREFIX;
                GOT_PREFIX: state_d = GOT_DATA;
                GOT_DATA:   state_d = (ir == EXT_OP) ? GOT_PREFIX : IDLE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset)                          ext_byte <= '0;
        else if (fire && state_q == GOT_PREFIX)  ext_byte <= ir[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (sync_reset)                        nop_count <= '0;
        else if (count_nop && nop_count != '1) nop_count <= nop_count + 1'b1;
    end

    always_comb begin
        reg_en     = raw.reg_en;
        source_sel = raw.source_sel;
        i_sel      = raw.i_sel;
        x_sel      = raw.x_sel;
        y_sel      = raw.y_sel;
        jmp        = raw.jmp;
        jmp_nz     = raw.jmp_nz;
        imm_ext    = use_ext;
        ir_nibble  = use_ext ? ext_byte : DATA_W'(ir[3:0]);
        if (sync_reset) begin
            reg_en     = 9'h1FF;
            source_sel = SRC_RST;
            i_sel      = 1'b0;
            x_sel      = 1'b0;
            y_sel      = 1'b0;
            jmp        = 1'b0;
            jmp_nz     = 1'b0;
            imm_ext    = 1'b0;
        end else if (!fire || state_q == GOT_PREFIX) begin
            reg_en = '0;
            jmp    = 1'b0;
            jmp_nz = 1'b0;
        end else if (is_nop) begin
            reg_en = '0;
        end
    end

    assign from_ID   = reg_en[7:0];
    assign ext_state = state_q;

endmodule

// File: tb/tb_instr_decoder_ext.sv
// Bench for instr_decoder_ext: default instance plus a DATA_W=8 / NOPCNT_W=2 instance on
// shared stimulus, directed scenarios and a randomized run against a byte-level reference model.
module tb_instr_decoder_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sync_reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] next_instr = 8'h00;

    logic [7:0] ir_a, ir_b, from_ID_a, from_ID_b;
    logic       dec_valid_a, dec_valid_b, imm_ext_a, imm_ext_b;
    logic [3:0] ir_nibble_a;
    logic [7:0] ir_nibble_b;
    logic [8:0] reg_en_a, reg_en_b;
    logic [3:0] source_sel_a, source_sel_b;
    logic       i_sel_a, x_sel_a, y_sel_a, jmp_a, jmp_nz_a;
    logic       i_sel_b, x_sel_b, y_sel_b, jmp_b, jmp_nz_b;
    logic [1:0] ext_state_a, ext_state_b;
    logic [7:0] nop_count_a;
    logic [1:0] nop_count_b;

    int n_cmp = 0;
    int n_err = 0;

    instr_decoder_ext dut_a (
        .clk(clk), .sync_reset(sync_reset), .next_instr(next_instr), .instr_valid(instr_valid),
        .stall(stall), .ir(ir_a), .dec_valid(dec_valid_a), .ir_nibble(ir_nibble_a),
        .imm_ext(imm_ext_a), .reg_en(reg_en_a), .from_ID(from_ID_a), .source_sel(source_sel_a),
        .i_sel(i_sel_a), .x_sel(x_sel_a), .y_sel(y_sel_a), .jmp(jmp_a), .jmp_nz(jmp_nz_a),
        .ext_state(ext_state_a), .nop_count(nop_count_a)
    );

    instr_decoder_ext #(.DATA_W(8), .NOPCNT_W(2)) dut_b (
        .clk(clk), .sync_reset(sync_reset), .next_instr(next_instr), .instr_valid(instr_valid),
        .stall(stall), .ir(ir_b), .dec_valid(dec_valid_b), .ir_nibble(ir_nibble_b),
        .imm_ext(imm_ext_b), .reg_en(reg_en_b), .from_ID(from_ID_b), .source_sel(source_sel_b),
        .i_sel(i_sel_b), .x_sel(x_sel_b), .y_sel(y_sel_b), .jmp(jmp_b), .jmp_nz(jmp_nz_b),
        .ext_state(ext_state_b), .nop_count(nop_count_b)
    );

    // Reference model state: the byte under decode, its valid flag, prefix phase
    // (0 none, 1 expecting data, 2 data captured), captured data byte and NOP tallies.
    logic [7:0] m_ir = 8'h00, m_xb = 8'h00;
    bit         m_dv = 0;
    int         m_st = 0, m_cnt_a = 0, m_cnt_b = 0;

    typedef struct packed {
        logic [8:0] reg_en;
        logic [3:0] src;
        logic       i_sel, x_sel, y_sel, jmp, jnz, imm;
        logic [7:0] nib;
    } exp_t;

    function automatic bit is_nop(input logic [7:0] b);
        return (b == 8'hC8) || (b == 8'hCF) || (b == 8'hD8) || (b == 8'hDF);
    endfunction

    function automatic exp_t ref_out(input logic [7:0] b, input bit dv, input int st,
                                     input logic [7:0] xb, input bit rst, input bit stl);
        exp_t e;
        int   d, s;
        bit   immcls;
        e       = '0;
        e.i_sel = 1'b1;
        immcls  = 0;
        if (b < 8'h80) begin
            d = int'(b[6:4]);
            e.reg_en = 9'(1 << d);
            if (d >= 6) e.reg_en[6] = 1'b1;
            e.src   = 4'd8;
            e.i_sel = (d != 6);
            immcls  = 1;
        end else if (b < 8'hC0) begin
            d = int'(b[5:3]);
            s = int'(b[2:0]);
            e.reg_en = 9'(1 << d);
            if (d >= 6 || s == 7) e.reg_en[6] = 1'b1;
            e.src   = 4'((s == 4) ? 4 : (s == d) ? 9 : s);
            e.i_sel = (d != 6);
        end else if (b < 8'hE0) begin
            e.reg_en = 9'h010;
            e.x_sel  = b[4];
            e.y_sel  = b[3];
            e.src    = {1'b0, b[2:0]};
        end else begin
            e.jmp  = (b < 8'hF0);
            e.jnz  = (b >= 8'hF0);
            immcls = 1;
        end
        if (is_nop(b)) e.reg_en = '0;
        e.imm = immcls && dv && (st == 2) && !rst;
        e.nib = (immcls && dv && st == 2) ? xb : {4'h0, b[3:0]};
        if (rst) begin
            e.reg_en = 9'h1FF; e.src = 4'd10;
            e.i_sel = 0; e.x_sel = 0; e.y_sel = 0; e.jmp = 0; e.jnz = 0;
        end else if (!(dv && !stl) || st == 1) begin
            e.reg_en = '0; e.jmp = 0; e.jnz = 0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (sync_reset) begin
            m_ir <= 8'h00; m_dv <= 0; m_st <= 0; m_xb <= 8'h00; m_cnt_a <= 0; m_cnt_b <= 0;
        end else begin
            if (m_dv && !stall) begin
                if (m_st == 1) begin
                    m_xb <= m_ir;
                    m_st <= 2;
                end else begin
                    m_st <= (m_ir == 8'hC8) ? 1 : 0;
                    if (is_nop(m_ir)) begin
                        if (m_cnt_a < 255) m_cnt_a <= m_cnt_a + 1;
                        if (m_cnt_b < 3)   m_cnt_b <= m_cnt_b + 1;
                    end
                end
            end
            if (!stall) begin
                m_dv <= instr_valid;
                if (instr_valid) m_ir <= next_instr;
            end
        end
    end

    // One clock: inputs change just after the edge, outputs are observed at the falling edge.
    task automatic cyc(input bit r, input bit v, input logic [7:0] b, input bit s);
        @(posedge clk);
        #1;
        sync_reset = r; instr_valid = v; next_instr = b; stall = s;
        @(negedge clk);
    endtask

    task automatic test_reset;
        cyc(1, 0, 8'h00, 0);
        n_cmp++;
        if ({reg_en_a, source_sel_a, jmp_a, jmp_nz_a, imm_ext_a} !== {9'h1FF, 4'd10, 3'b000}) begin
            n_err++; $display("FAIL reset_override_a: got %h want %h",
                {reg_en_a, source_sel_a, jmp_a, jmp_nz_a, imm_ext_a}, {9'h1FF, 4'd10, 3'b000});
        end
        n_cmp++;
        if ({reg_en_b, source_sel_b, i_sel_b, x_sel_b, y_sel_b} !== {9'h1FF, 4'd10, 3'b000}) begin
            n_err++; $display("FAIL reset_override_b: got %h want %h",
                {reg_en_b, source_sel_b, i_sel_b, x_sel_b, y_sel_b}, {9'h1FF, 4'd10, 3'b000});
        end
        cyc(0, 0, 8'h00, 0);
        n_cmp++;
        if ({dec_valid_a, reg_en_a, ext_state_a, nop_count_a, ir_a} !== {1'b0, 9'h000, 2'd0, 8'd0, 8'h00}) begin
            n_err++; $display("FAIL reset_release: got %h want %h",
                {dec_valid_a, reg_en_a, ext_state_a, nop_count_a, ir_a}, {1'b0, 9'h000, 2'd0, 8'd0, 8'h00});
        end
    endtask

    task automatic test_stream;
        logic [7:0] bytes [4];
        logic [8:0] want_en [4];
        logic [3:0] want_src [4];
        bytes = '{8'h25, 8'h9A, 8'h92, 8'h84};
        want_en = '{9'h004, 9'h008, 9'h004, 9'h001};
        want_src = '{4'd8, 4'd2, 4'd9, 4'd4};
        for (int i = 0; i < 5; i++) begin
            cyc(0, i < 4, (i < 4) ? bytes[i] : 8'h00, 0);
            if (i > 0) begin
                n_cmp++;
                if ({reg_en_a, source_sel_a, reg_en_b} !== {want_en[i-1], want_src[i-1], want_en[i-1]}) begin
                    n_err++; $display("FAIL stream_%0d: got %h want %h", i - 1,
                        {reg_en_a, source_sel_a, reg_en_b}, {want_en[i-1], want_src[i-1], want_en[i-1]});
                end
            end
            if (i == 1) begin
                n_cmp++;
                if ({ir_nibble_a, ir_nibble_b, imm_ext_a} !== {4'h5, 8'h05, 1'b0}) begin
                    n_err++; $display("FAIL stream_nibble: got %h want %h",
                        {ir_nibble_a, ir_nibble_b, imm_ext_a}, {4'h5, 8'h05, 1'b0});
                end
            end
        end
    endtask

    task automatic test_ext_prefix;
        cyc(0, 1, 8'hC8, 0);
        cyc(0, 1, 8'h5A, 0);
        n_cmp++;
        if ({reg_en_b, ext_state_b} !== {9'h000, 2'd0}) begin
            n_err++; $display("FAIL ext_prefix_byte: got %h want %h", {reg_en_b, ext_state_b}, {9'h000, 2'd0});
        end
        cyc(0, 1, 8'h03, 0);
        n_cmp++;
        if ({reg_en_b, ext_state_b, imm_ext_b} !== {9'h000, 2'd1, 1'b0}) begin
            n_err++; $display("FAIL ext_data_byte: got %h want %h",
                {reg_en_b, ext_state_b, imm_ext_b}, {9'h000, 2'd1, 1'b0});
        end
        cyc(0, 1, 8'hC8, 0);
        n_cmp++;
        if ({reg_en_b, ir_nibble_b, imm_ext_b, ir_nibble_a, imm_ext_a} !== {9'h001, 8'h5A, 1'b1, 4'hA, 1'b1}) begin
            n_err++; $display("FAIL ext_consumer: got %h want %h",
                {reg_en_b, ir_nibble_b, imm_ext_b, ir_nibble_a, imm_ext_a}, {9'h001, 8'h5A, 1'b1, 4'hA, 1'b1});
        end
        cyc(0, 1, 8'h5A, 0);
        cyc(0, 1, 8'h9A, 0);
        cyc(0, 0, 8'h00, 0);
        n_cmp++;
        if ({reg_en_b, source_sel_b, imm_ext_b, ir_nibble_b} !== {9'h008, 4'd2, 1'b0, 8'h0A}) begin
            n_err++; $display("FAIL ext_dropped_move: got %h want %h",
                {reg_en_b, source_sel_b, imm_ext_b, ir_nibble_b}, {9'h008, 4'd2, 1'b0, 8'h0A});
        end
        cyc(0, 0, 8'h00, 0);
    endtask

    task automatic test_stall;
        cyc(0, 1, 8'hE7, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 8'h11, 1);
            n_cmp++;
            if ({jmp_a, jmp_nz_a, ir_a, dec_valid_a} !== {2'b00, 8'hE7, 1'b1}) begin
                n_err++; $display("FAIL stall_hold_%0d: got %h want %h", i,
                    {jmp_a, jmp_nz_a, ir_a, dec_valid_a}, {2'b00, 8'hE7, 1'b1});
            end
        end
        cyc(0, 0, 8'h00, 0);
        n_cmp++;
        if ({jmp_a, jmp_b, ir_a, ir_nibble_a} !== {2'b11, 8'hE7, 4'h7}) begin
            n_err++; $display("FAIL stall_release: got %h want %h",
                {jmp_a, jmp_b, ir_a, ir_nibble_a}, {2'b11, 8'hE7, 4'h7});
        end
        cyc(0, 0, 8'h00, 0);
        n_cmp++;
        if ({jmp_a, dec_valid_a} !== 2'b00) begin
            n_err++; $display("FAIL stall_single_jump: got %b want %b", {jmp_a, dec_valid_a}, 2'b00);
        end
    endtask

    task automatic test_reset_mid_prefix;
        cyc(0, 1, 8'hC8, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 0);
        n_cmp++;
        if (ext_state_a !== 2'd1) begin
            n_err++; $display("FAIL midpfx_entered: got %0d want %0d", ext_state_a, 1);
        end
        cyc(0, 1, 8'h5A, 0);
        n_cmp++;
        if ({ext_state_a, ext_state_b, dec_valid_a} !== {2'd0, 2'd0, 1'b0}) begin
            n_err++; $display("FAIL midpfx_reset: got %h want %h",
                {ext_state_a, ext_state_b, dec_valid_a}, {2'd0, 2'd0, 1'b0});
        end
        cyc(0, 0, 8'h00, 0);
        n_cmp++;
        if ({reg_en_b, source_sel_b, imm_ext_b, ir_nibble_b, i_sel_b} !== {9'h020, 4'd8, 1'b0, 8'h0A, 1'b1}) begin
            n_err++; $display("FAIL midpfx_decode: got %h want %h",
                {reg_en_b, source_sel_b, imm_ext_b, ir_nibble_b, i_sel_b}, {9'h020, 4'd8, 1'b0, 8'h0A, 1'b1});
        end
    endtask

    task automatic test_nop_saturate;
        int wa, wb;
        cyc(1, 0, 8'h00, 0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, k < 5, 8'hCF, 0);
            if (k >= 2 && k <= 6) begin
                wa = k - 1;
                wb = (k - 1 > 3) ? 3 : k - 1;
                n_cmp++;
                if ({nop_count_a, nop_count_b} !== {8'(wa), 2'(wb)}) begin
                    n_err++; $display("FAIL nop_count_%0d: got %0d/%0d want %0d/%0d", k,
                        nop_count_a, nop_count_b, wa, wb);
                end
            end
        end
    endtask

    task automatic test_random;
        exp_t        e;
        logic [26:0] got, want;
        logic [7:0]  b;
        bit          r, v, s;
        for (int k = 0; k < 800; k++) begin
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 80);
            s = ($urandom_range(0, 99) < 20);
            case ($urandom_range(0, 5))
                0, 1:    b = 8'hC8;
                2:       b = ($urandom_range(0, 1) != 0) ? 8'hCF : 8'hDF;
                default: b = 8'($urandom);
            endcase
            cyc(r, v, b, s);
            e = ref_out(m_ir, m_dv, m_st, m_xb, sync_reset, stall);
            want = {e.reg_en, e.reg_en[7:0], e.src, e.i_sel, e.x_sel, e.y_sel, e.jmp, e.jnz, e.imm};
            got  = {reg_en_a, from_ID_a, source_sel_a, i_sel_a, x_sel_a, y_sel_a, jmp_a, jmp_nz_a, imm_ext_a};
            n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL rand_dec_a @%0d: got %h want %h", k, got, want);
            end
            got  = {reg_en_b, from_ID_b, source_sel_b, i_sel_b, x_sel_b, y_sel_b, jmp_b, jmp_nz_b, imm_ext_b};
            n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL rand_dec_b @%0d: got %h want %h", k, got, want);
            end
            n_cmp++;
            if ({ir_a, dec_valid_a, ext_state_a, nop_count_a, ext_state_b, nop_count_b} !==
                {m_ir, m_dv, 2'(m_st), 8'(m_cnt_a), 2'(m_st), 2'(m_cnt_b)}) begin
                n_err++; $display("FAIL rand_state @%0d: got %h want %h", k,
                    {ir_a, dec_valid_a, ext_state_a, nop_count_a, ext_state_b, nop_count_b},
                    {m_ir, m_dv, 2'(m_st), 8'(m_cnt_a), 2'(m_st), 2'(m_cnt_b)});
            end
            if (!sync_reset) begin
                n_cmp++;
                if ({ir_nibble_a, ir_nibble_b} !== {e.nib[3:0], e.nib}) begin
                    n_err++; $display("FAIL rand_nibble @%0d: got %h want %h", k,
                        {ir_nibble_a, ir_nibble_b}, {e.nib[3:0], e.nib});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ext_prefix();
        test_stall();
        test_reset_mid_prefix();
        test_nop_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
